iob_uart_console: RTL and testbench

Testbench-side console engine that sits directly downstream of the simulation top's tester UART port. It owns the native register bus into the tester UART, runs the UART init sequence after reset, and then continuously moves bytes in both directions. Outgoing bytes come from a byte stream and are written to TXDATA; incoming bytes are polled from RXDATA and presented on an output stream, for a console printer or file loader.

---
 rtl/iob_uart_console_pkg.sv | 9 +
 rtl/iob_native_master.sv | 39 +++
 rtl/iob_uart_console.sv | 147 ++++++++++++++
 tb/tb_iob_uart_console.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/iob_uart_console_pkg.sv
// iob_uart_console_pkg: shared FSM states, strobe codes and arbitration encodings
package iob_uart_console_pkg;
  typedef enum logic [3:0] {
    INIT_DIV, INIT_TXEN, INIT_RXEN, IDLE, GAP, POLL_TX, WR_TX, POLL_RX, RD_RX
  } state_t;
  localparam logic [3:0] RD_STRB = 4'h0;
  localparam logic [3:0] WR_STRB = 4'hF;
  typedef enum logic {LAST_TX, LAST_RX} last_t;
endpackage

// File: rtl/iob_native_master.sv
// iob_native_master: single-request native bus master, holds valid until ready
module iob_native_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready
);
  // completion has priority over a new request, so a finished access is never reissued
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_valid <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
    end else if (bus_valid) begin
      bus_valid <= !bus_ready;
    end else if (req) begin
      bus_valid <= 1'b1;
      bus_addr  <= addr;
      bus_wdata <= wdata;
      bus_wstrb <= wstrb;
    end
  end
  assign done  = bus_valid & bus_ready;
  assign rdata = bus_rdata;
endmodule

// File: rtl/iob_uart_console.sv
// iob_uart_console: inits the tester UART, then round-robins TX writes and RX polls
module iob_uart_console
  import iob_uart_console_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 32,
  parameter int DIV_ADDR     = 1,
  parameter int TXEN_ADDR    = 2,
  parameter int RXEN_ADDR    = 3,
  parameter int TXREADY_ADDR = 4,
  parameter int RXREADY_ADDR = 5,
  parameter int TXDATA_ADDR  = 6,
  parameter int RXDATA_ADDR  = 7,
  parameter int DIV_VAL      = 16,
  parameter int POLL_GAP     = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              uart_valid,
  output logic [ADDR_W-1:0] uart_addr,
  output logic [DATA_W-1:0] uart_wdata,
  output logic [3:0]        uart_wstrb,
  input  logic [DATA_W-1:0] uart_rdata,
  input  logic              uart_ready,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              init_done
);
  state_t state, state_n;
  last_t last;
  logic tx_full;
  logic [7:0] tx_byte;
  logic [15:0] gap_cnt;
  logic req, done;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [3:0] wstrb;
  logic unused;
  assign unused = ^rdata[DATA_W-1:8];
  assign tx_ready = init_done & !tx_full;
  always_comb begin
    req = 1'b0;
    addr = '0;
    wdata = '0;
    wstrb = RD_STRB;
    state_n = state;
    case (state)
      INIT_DIV: begin
        req = 1'b1;
        addr = ADDR_W'(DIV_ADDR);
        wdata = DATA_W'(DIV_VAL);
        wstrb = WR_STRB;
        state_n = done ? INIT_TXEN : state;
      end
      INIT_TXEN: begin
        req = 1'b1;
        addr = ADDR_W'(TXEN_ADDR);
        wdata = DATA_W'(1);
        wstrb = WR_STRB;
        state_n = done ? INIT_RXEN : state;
      end
      INIT_RXEN: begin
        req = 1'b1;
        addr = ADDR_W'(RXEN_ADDR);
        wdata = DATA_W'(1);
        wstrb = WR_STRB;
        state_n = done ? IDLE : state;
      end
      IDLE: state_n = (tx_full && (last == LAST_RX || rx_valid)) ? POLL_TX : !rx_valid ? POLL_RX : IDLE;
      GAP: state_n = (gap_cnt == 16'(POLL_GAP - 1)) ? IDLE : GAP;
      POLL_TX: begin
        req = 1'b1;
        addr = ADDR_W'(TXREADY_ADDR);
        state_n = !done ? state : rdata[0] ? WR_TX : GAP;
      end
      WR_TX: begin
        req = 1'b1;
        addr = ADDR_W'(TXDATA_ADDR);
        wdata = DATA_W'(tx_byte);
        wstrb = WR_STRB;
        state_n = done ? IDLE : state;
      end
      POLL_RX: begin
        req = 1'b1;
        addr = ADDR_W'(RXREADY_ADDR);
        state_n = !done ? state : rdata[0] ? RD_RX : GAP;
      end
      RD_RX: begin
        req = 1'b1;
        addr = ADDR_W'(RXDATA_ADDR);
        state_n = done ? IDLE : state;
      end
      default: state_n = INIT_DIV;
    endcase
  end
  // last may also flip on a successful poll; the following data access sets the same value
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT_DIV;
      last <= LAST_RX;
      tx_full <= 1'b0;
      tx_byte <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      init_done <= 1'b0;
      gap_cnt <= '0;
    end else begin
      state <= state_n;
      gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : '0;
      if (state == INIT_RXEN && done) init_done <= 1'b1;
      if (tx_valid && tx_ready) begin
        tx_full <= 1'b1;
        tx_byte <= tx_data;
      end else if (state == WR_TX && done) begin
        tx_full <= 1'b0;
      end
      if (state == RD_RX && done) begin
        rx_data <= rdata[7:0];
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (done && (state == POLL_TX || state == WR_TX)) last <= LAST_TX;
      if (done && (state == POLL_RX || state == RD_RX)) last <= LAST_RX;
    end
  end
  iob_native_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_master (
    .clk(clk),
    .rst(rst),
    .req(req),
    .addr(addr),
    .wdata(wdata),
    .wstrb(wstrb),
    .done(done),
    .rdata(rdata),
    .bus_valid(uart_valid),
    .bus_addr(uart_addr),
    .bus_wdata(uart_wdata),
    .bus_wstrb(uart_wstrb),
    .bus_rdata(uart_rdata),
    .bus_ready(uart_ready)
  );
endmodule

// File: tb/tb_iob_uart_console.sv
// tb_iob_uart_console: directed bench with a UART register slave model and access log
module tb_iob_uart_console;
  localparam int A_DIV = 1, A_TXEN = 2, A_RXEN = 3, A_TXRDY = 4, A_RXRDY = 5, A_TXD = 6, A_RXD = 7;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_valid;
  logic [3:0] uart_addr;
  logic [31:0] uart_wdata;
  logic [3:0] uart_wstrb;
  logic [31:0] uart_rdata = '0;
  logic uart_ready = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready = 1'b0;
  logic init_done;
  int checks = 0, errors = 0;
  int lat = 1;
  logic [2:0] txr_pat = 3'b100;
  logic rxr = 1'b1;
  logic [7:0] rxb = 8'h5A;
  int cnt = 0, txr_n = 0, cyc = 0;
  int la[$];
  logic [31:0] lw[$];
  logic [3:0] ls[$];
  int lt[$];
  int pat[4] = '{A_RXRDY, A_RXD, A_TXRDY, A_TXD};
  iob_uart_console #(
    .DIV_ADDR(A_DIV), .TXEN_ADDR(A_TXEN), .RXEN_ADDR(A_RXEN), .TXREADY_ADDR(A_TXRDY),
    .RXREADY_ADDR(A_RXRDY), .TXDATA_ADDR(A_TXD), .RXDATA_ADDR(A_RXD)
  ) dut (
    .clk(clk), .rst(rst),
    .uart_valid(uart_valid), .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_wstrb(uart_wstrb),
    .uart_rdata(uart_rdata), .uart_ready(uart_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .init_done(init_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // slave answers lat cycles after it first sees valid and logs each completed access
  always @(posedge clk) begin
    if (rst) begin
      uart_ready <= 1'b0;
      cnt <= 0;
    end else if (uart_valid && !uart_ready) begin
      if (cnt + 1 >= lat) begin
        uart_ready <= 1'b1;
        cnt <= 0;
        uart_rdata <= (uart_addr == A_TXRDY) ? {31'b0, (txr_n < 3) ? txr_pat[txr_n[1:0]] : 1'b1} :
                      (uart_addr == A_RXRDY) ? {31'b0, rxr} :
                      (uart_addr == A_RXD)   ? {24'hFFFFFF, rxb} : 32'hDEADBEEF;
        if (uart_addr == A_TXRDY) txr_n <= txr_n + 1;
        la.push_back(int'(uart_addr));
        lw.push_back(uart_wdata);
        ls.push_back(uart_wstrb);
        lt.push_back(cyc);
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      uart_ready <= 1'b0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int base;
    logic [3:0] a0;
    logic [31:0] w0;
    logic [3:0] s0;
    repeat (3) @(negedge clk);
    chk("rst_valid", uart_valid, 0);
    chk("rst_addr", uart_addr, 0);
    chk("rst_wdata", uart_wdata, 0);
    chk("rst_wstrb", uart_wstrb, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_init_done", init_done, 0);
    rst = 1'b0;
    for (int i = 0; i < 100 && !init_done; i++) @(negedge clk);
    chk("init_done", init_done, 1);
    chk("init_count", la.size(), 3);
    chk("div_addr", la[0], A_DIV);
    chk("div_data", lw[0], 16);
    chk("div_strb", ls[0], 4'hF);
    chk("txen_addr", la[1], A_TXEN);
    chk("txen_data", lw[1], 1);
    chk("rxen_addr", la[2], A_RXEN);
    chk("rxen_data", lw[2], 1);
    chk("rxen_strb", ls[2], 4'hF);
    chk("init_spacing", lt[1] - lt[0], 3);
    chk("tx_ready_after_init", tx_ready, 1);
    for (int i = 0; i < 50 && !rx_valid; i++) @(negedge clk);
    chk("rx_valid", rx_valid, 1);
    chk("rx_data", rx_data, 8'h5A);
    chk("rx_poll_addr", la[3], A_RXRDY);
    chk("rx_poll_strb", ls[3], 0);
    chk("rx_read_addr", la[4], A_RXD);
    repeat (40) @(negedge clk);
    chk("rx_hold_no_poll", la.size(), 5);
    chk("rx_valid_held", rx_valid, 1);
    tx_data = 8'h41;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("tx_ready_full", tx_ready, 0);
    for (int i = 0; i < 200 && la.size() < 9; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("tx_count", la.size(), 9);
    chk("tx_poll1", la[5], A_TXRDY);
    chk("tx_poll1_strb", ls[5], 0);
    chk("tx_poll2", la[6], A_TXRDY);
    chk("tx_poll3", la[7], A_TXRDY);
    chk("tx_write_addr", la[8], A_TXD);
    chk("tx_write_data", lw[8], 32'h41);
    chk("tx_write_strb", ls[8], 4'hF);
    chk("tx_gap1", lt[6] - lt[5], 12);
    chk("tx_gap2", lt[7] - lt[6], 12);
    chk("tx_write_spacing", lt[8] - lt[7], 3);
    chk("tx_ready_back", tx_ready, 1);
    rxb = 8'h33;
    tx_data = 8'h77;
    tx_valid = 1'b1;
    rx_ready = 1'b1;
    base = la.size();
    @(negedge clk);
    chk("rx_consume", rx_valid, 0);
    for (int i = 0; i < 400 && la.size() < base + 12; i++) @(negedge clk);
    for (int k = 0; k < 12; k++) chk($sformatf("alt_%0d", k), la[base + k], pat[k % 4]);
    chk("alt_tx_data", lw[base + 3], 32'h77);
    chk("alt_rx_data", rx_data, 8'h33);
    tx_valid = 1'b0;
    rxr = 1'b0;
    lat = 20;
    for (int i = 0; i < 100 && uart_valid; i++) @(negedge clk);
    for (int i = 0; i < 200 && !uart_valid; i++) @(negedge clk);
    chk("slow_rise", uart_valid, 1);
    a0 = uart_addr;
    w0 = uart_wdata;
    s0 = uart_wstrb;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("slow_valid_%0d", i), uart_valid, 1);
      chk($sformatf("slow_addr_%0d", i), uart_addr, a0);
      chk($sformatf("slow_wdata_%0d", i), {uart_wdata, uart_wstrb}, {w0, s0});
    end
    for (int i = 0; i < 100 && uart_valid; i++) @(negedge clk);
    for (int i = 0; i < 300 && !uart_valid; i++) @(negedge clk);
    chk("held_read_rise", uart_valid, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", uart_valid, 0);
    chk("mid_rst_init_done", init_done, 0);
    chk("mid_rst_tx_ready", tx_ready, 0);
    chk("mid_rst_rx_data", rx_data, 0);
    lat = 1;
    rst = 1'b0;
    base = la.size();
    for (int i = 0; i < 100 && !init_done; i++) @(negedge clk);
    chk("reinit_done", init_done, 1);
    chk("reinit_count", la.size(), base + 3);
    chk("reinit_div", la[base], A_DIV);
    chk("reinit_div_data", lw[base], 16);
    chk("reinit_txen", la[base + 1], A_TXEN);
    chk("reinit_rxen", la[base + 2], A_RXEN);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
